rbm_argmax: RTL and testbench
=============================

RBM_ARGMAX -- requirements
Module: rbm_argmax

Interface
REQ-001 Parameter output_dim, default 10: number of class scores produced by the RBM classifier layer.
REQ-002 Parameter bitlength, default 12: width of each score; two's complement signed.
REQ-003 Parameter idx_width, default 4: index width, equal to ceil(log2(output_dim)) with a minimum of 1.
REQ-004 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port finish, input, 1: completion level from the upstream RBM core.
REQ-007 Port OutputDataPort, input, output_dim*bitlength: packed scores; element i occupies bits [i*bitlength +: bitlength].
REQ-008 Port result_ready, input, 1: consumer accepts the result.
REQ-009 Port class_idx, output, idx_width: index of the maximum score.
REQ-010 Port max_value, output, bitlength: the maximum score.
REQ-011 Port result_valid, output, 1: class_idx and max_value are valid.
REQ-012 Port busy, output, 1: a scan is in progress (SCAN state).
REQ-013 Port tie, output, 1: more than one element equals max_value.
REQ-014 Port dropped, output, 1: sticky flag; a finish rising edge was ignored.

Function
REQ-015 The block SHALL register finish and detect a rising edge as finish=1 while the registered finish=0.
REQ-016 The block SHALL implement states IDLE, SCAN and DONE.
REQ-017 In IDLE, a rising edge of finish SHALL capture all of OutputDataPort into an internal bank, set element 0 as the running max, set index 0, clear tie, and enter SCAN with counter=1.
REQ-018 In SCAN, each cycle SHALL compare bank[counter] with the running max using a signed comparison, then increment counter.
REQ-019 Strictly greater SHALL replace the max and index and clear tie; equal SHALL set tie and keep the lower index.
REQ-020 SCAN SHALL exit to DONE on the cycle that compares element output_dim-1.
REQ-021 If output_dim=1, the block SHALL go directly from the capture to DONE.
REQ-022 Latency SHALL be fixed: when the edge is detected at clock edge k, result_valid rises at clock edge k+output_dim.
REQ-023 In DONE, result_valid=1 and the outputs SHALL stay stable until the cycle in which result_ready=1; on that edge the block SHALL return to IDLE with result_valid=0.
REQ-024 If result_ready is already 1 when DONE is entered, result_valid SHALL be high for exactly one cycle.
REQ-025 A finish rising edge in SCAN or DONE SHALL NOT disturb the bank or the outputs, and SHALL set dropped.
REQ-026 dropped SHALL clear only on reset.
REQ-027 Changes on OutputDataPort after capture SHALL NOT affect the result.
REQ-028 A finish held high SHALL trigger only one scan; a new scan requires finish to fall and rise again.
REQ-029 The value 0111_1111_1111 (Inf) SHALL compare as the largest value, and 1000_0000_0000 as the smallest.

Reset
REQ-030 Asserting reset low SHALL immediately force IDLE and set class_idx=0, max_value=0, result_valid=0, busy=0, tie=0, dropped=0, counter=0, and the registered finish=0.
REQ-031 Reset asserted during SCAN or DONE SHALL abort the operation with no result emitted.
REQ-032 If finish is high at reset release, the block SHALL treat it as a rising edge on the first clock after release.

Verification
REQ-033 Scores {3,-5,100,7,0,2,1,-1,99,4} with finish rising and result_ready=1 -> result_valid high for one cycle, 10 cycles after edge detection; class_idx=2, max_value=100, tie=0.
REQ-034 All ten scores equal -2048 -> class_idx=0, max_value=-2048, tie=1.
REQ-035 Score 9 = 2047 (Inf), all others 2046 -> class_idx=9, tie=0; repeat with scores 4 and 9 both 2047 -> class_idx=4, tie=1.
REQ-036 result_ready held at 0 for 5 cycles after DONE -> outputs stable for those 5 cycles; then result_ready=1 -> IDLE on that edge; a second finish pulse during the hold -> dropped=1 and the result unchanged.
REQ-037 reset pulsed low at scan cycle 4 -> all outputs 0 at once, no result_valid; the next finish edge produces a correct result.
REQ-038 OutputDataPort changed to all 0x7FF one cycle after capture -> the result reflects the captured values only.

Source files
------------

// File: rtl/rbm_argmax.sv
// Argmax over the class scores of an RBM classifier layer: snapshot on finish rising edge,
// serial signed scan (one element per cycle), result held until the consumer accepts it.
module rbm_argmax #(
    parameter int output_dim = 10,
    parameter int bitlength  = 12,
    parameter int idx_width  = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               finish,
    input  logic [output_dim*bitlength-1:0]    OutputDataPort,
    input  logic                               result_ready,
    output logic [idx_width-1:0]               class_idx,
    output logic signed [bitlength-1:0]        max_value,
    output logic                               result_valid,
    output logic                               busy,
    output logic                               tie,
    output logic                               dropped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [idx_width-1:0] LAST = idx_width'(output_dim - 1);

    state_t                      state;
    logic                        finish_p0;
    logic                        rise_p0;
    logic [idx_width-1:0]        counter;
    logic signed [bitlength-1:0] bank [output_dim];
    logic signed [bitlength-1:0] cand;
    logic signed [bitlength-1:0] first;
    logic                        start;

    assign first = OutputDataPort[bitlength-1:0];
    assign start = (state == IDLE) && rise_p0;

    // Stage p0: sample finish and register its rising edge as a one-cycle event
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            finish_p0 <= 1'b0;
            rise_p0   <= 1'b0;
        end else begin
            finish_p0 <= finish;
            rise_p0   <= finish & ~finish_p0;
        end
    end

    // Stage p1: snapshot of every score, only written when a scan starts
    always_ff @(posedge clock) begin
        if (start) begin
            for (int i = 0; i < output_dim; i++) begin
                bank[i] <= OutputDataPort[i*bitlength +: bitlength];
            end
        end
    end

    always_comb begin
        cand = bank[0];
        for (int i = 0; i < output_dim; i++) begin
            if (counter == idx_width'(i)) begin
                cand = bank[i];
            end
        end
    end

    // Stage p2: serial compare against the running maximum
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= '0;
            class_idx    <= '0;
            max_value    <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            tie          <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise_p0) begin
                        max_value <= first;
                        class_idx <= '0;
                        tie       <= 1'b0;
                        if (output_dim == 1) begin
                            state        <= DONE;
                            result_valid <= 1'b1;
                        end else begin
                            state   <= SCAN;
                            busy    <= 1'b1;
                            counter <= idx_width'(1);
                        end
                    end
                end
                SCAN: begin
                    if (rise_p0) begin
                        dropped <= 1'b1;
                    end
                    // Ties keep the lower index, so only a strictly larger score moves it
                    if (cand > max_value) begin
                        max_value <= cand;
                        class_idx <= counter;
                        tie       <= 1'b0;
                    end else if (cand == max_value) begin
                        tie <= 1'b1;
                    end
                    counter <= counter + idx_width'(1);
                    if (counter == LAST) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        counter      <= '0;
                    end
                end
                DONE: begin
                    if (rise_p0) begin
                        dropped <= 1'b1;
                    end
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rbm_argmax.sv
// Directed and randomized checks of rbm_argmax against a first-maximum reference model.
module tb_rbm_argmax;

    localparam int N  = 10;
    localparam int W  = 12;
    localparam int IW = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 finish;
    logic [N*W-1:0]       data;
    logic                 result_ready;
    logic [IW-1:0]        class_idx;
    logic signed [W-1:0]  max_value;
    logic                 result_valid;
    logic                 busy;
    logic                 tie;
    logic                 dropped;

    logic signed [W-1:0]  sc [N];
    int                   checks = 0;
    int                   errors = 0;
    bit                   exp_drop = 1'b0;

    rbm_argmax #(.output_dim(N), .bitlength(W), .idx_width(IW)) dut (
        .clock          (clock),
        .reset          (reset),
        .finish         (finish),
        .OutputDataPort (data),
        .result_ready   (result_ready),
        .class_idx      (class_idx),
        .max_value      (max_value),
        .result_valid   (result_valid),
        .busy           (busy),
        .tie            (tie),
        .dropped        (dropped)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first index holding the largest signed score; tie if it occurs more than once
    task automatic model(output int idx, output logic signed [W-1:0] mx, output bit t);
        int cnt;
        idx = 0;
        mx  = sc[0];
        for (int i = 1; i < N; i++) begin
            if (sc[i] > mx) begin
                mx  = sc[i];
                idx = i;
            end
        end
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (sc[i] == mx) cnt++;
        end
        t = (cnt > 1);
    endtask

    task automatic set_data();
        for (int i = 0; i < N; i++) data[i*W +: W] = sc[i];
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_idx"},   32'(class_idx), 32'd0);
        chk({tag, "_max"},   32'(max_value), 32'd0);
        chk({tag, "_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_tie"},   32'(tie), 32'd0);
        chk({tag, "_drop"},  32'(dropped), 32'd0);
    endtask

    // Leaves simulation #1 after the clock edge at which the rising edge is detected
    task automatic launch(input int hold);
        set_data();
        finish       = 1'b0;
        result_ready = (hold == 0);
        @(posedge clock); #1;
        finish = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic observe(input bit keep, input bit chg, input int hold, input bit pulse);
        int                  eidx;
        logic signed [W-1:0] emax;
        bit                  etie;
        model(eidx, emax, etie);
        if (!keep) finish = 1'b0;
        for (int c = 1; c <= N; c++) begin
            @(posedge clock); #1;
            chk("valid_latency", 32'(result_valid), 32'(c == N));
            chk("busy_scan", 32'(busy), 32'(c < N));
            if (c == 1 && chg) data = {N{12'h7FF}};
        end
        chk("class_idx", 32'(class_idx), 32'(eidx));
        chk("max_value", 32'(max_value), 32'(emax));
        chk("tie", 32'(tie), 32'(etie));
        chk("dropped", 32'(dropped), 32'(exp_drop));
        for (int h = 1; h <= hold; h++) begin
            @(posedge clock); #1;
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_idx", 32'(class_idx), 32'(eidx));
            chk("hold_max", 32'(max_value), 32'(emax));
            chk("hold_tie", 32'(tie), 32'(etie));
            if (pulse && h == 2) finish = 1'b1;
            if (pulse && h == 3) begin
                finish   = 1'b0;
                exp_drop = 1'b1;
            end
        end
        if (hold > 0) begin
            chk("hold_dropped", 32'(dropped), 32'(exp_drop));
            result_ready = 1'b1;
        end
        @(posedge clock); #1;
        chk("valid_release", 32'(result_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        if (keep) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clock); #1;
                chk("held_finish_no_rescan", 32'(result_valid | busy), 32'd0);
            end
            finish = 1'b0;
        end
    endtask

    initial begin
        reset        = 1'b0;
        finish       = 1'b0;
        result_ready = 1'b1;
        data         = '0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Mixed scores, single-cycle valid
        sc = '{12'sd3, -12'sd5, 12'sd100, 12'sd7, 12'sd0, 12'sd2, 12'sd1, -12'sd1, 12'sd99, 12'sd4};
        launch(0);
        observe(1'b0, 1'b0, 0, 1'b0);

        // All minimum values
        for (int i = 0; i < N; i++) sc[i] = -12'sd2048;
        launch(0);
        observe(1'b0, 1'b0, 0, 1'b0);

        // Inf in the last slot, then two Inf values
        for (int i = 0; i < N; i++) sc[i] = 12'sd2046;
        sc[9] = 12'sd2047;
        launch(0);
        observe(1'b0, 1'b0, 0, 1'b0);
        sc[4] = 12'sd2047;
        launch(0);
        observe(1'b0, 1'b0, 0, 1'b0);

        // finish held high across the whole scan
        sc = '{-12'sd7, 12'sd12, -12'sd2048, 12'sd12, 12'sd5, 12'sd0, 12'sd11, 12'sd3, -12'sd1, 12'sd2};
        launch(0);
        observe(1'b1, 1'b0, 0, 1'b0);

        // Inputs overwritten right after capture
        sc = '{12'sd10, 12'sd20, 12'sd30, -12'sd40, 12'sd50, 12'sd5, 12'sd4, 12'sd3, 12'sd2, 12'sd1};
        launch(0);
        observe(1'b0, 1'b1, 0, 1'b0);

        // Consumer stalls 5 cycles with a second finish pulse during the hold
        sc = '{-12'sd3, -12'sd9, -12'sd1, -12'sd100, -12'sd1, -12'sd2000, -12'sd5, -12'sd6, -12'sd7, -12'sd8};
        launch(5);
        observe(1'b0, 1'b0, 5, 1'b1);

        // Reset in the middle of a scan
        for (int i = 0; i < N; i++) sc[i] = 12'(i * 37 - 100);
        launch(0);
        finish = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        exp_drop = 1'b0;
        check_reset_outputs("abort");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < N + 2; c++) begin
            @(posedge clock); #1;
            chk("abort_no_valid", 32'(result_valid), 32'd0);
        end
        launch(0);
        observe(1'b0, 1'b0, 0, 1'b0);

        // finish already high when reset is released
        sc = '{12'sd1, 12'sd2, 12'sd3, 12'sd4, 12'sd5, 12'sd6, 12'sd7, 12'sd8, 12'sd9, -12'sd10};
        set_data();
        @(negedge clock);
        reset  = 1'b0;
        finish = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        observe(1'b0, 1'b0, 0, 1'b0);

        // Randomized scores; small-range vectors force frequent ties
        for (int t = 0; t < 24; t++) begin
            bit narrow;
            int v;
            int hold;
            narrow = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < N; i++) begin
                if (narrow) begin
                    v     = $urandom_range(0, 4);
                    sc[i] = 12'(v - 2);
                end else begin
                    sc[i] = 12'($urandom);
                end
            end
            if ($urandom_range(0, 3) == 0) sc[$urandom_range(0, N - 1)] = 12'sh7FF;
            if ($urandom_range(0, 3) == 0) sc[$urandom_range(0, N - 1)] = 12'sh800;
            hold = $urandom_range(0, 3);
            launch(hold);
            observe(1'b0, 1'b0, hold, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
